// File: rtl/cfa_window_5x5.sv
`default_nettype none
// ============================================================================
// Module   : cfa_window_5x5
// Brief    : Raster Bayer CFA stream to 5x5 neighbourhood windows (interior only).
// Revision : 1.0
// ============================================================================
module cfa_window_5x5 #(
  parameter int PIX_W = 12,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sof,
  input  logic                     pix_valid,
  input  logic [PIX_W-1:0]         pix_in,
  output logic [PIX_W-1:0]         p_m2_m2,
  output logic [PIX_W-1:0]         p_m2_m1,
  output logic [PIX_W-1:0]         p_m2_p0,
  output logic [PIX_W-1:0]         p_m2_p1,
  output logic [PIX_W-1:0]         p_m2_p2,
  output logic [PIX_W-1:0]         p_m1_m2,
  output logic [PIX_W-1:0]         p_m1_m1,
  output logic [PIX_W-1:0]         p_m1_p0,
  output logic [PIX_W-1:0]         p_m1_p1,
  output logic [PIX_W-1:0]         p_m1_p2,
  output logic [PIX_W-1:0]         p_p0_m2,
  output logic [PIX_W-1:0]         p_p0_m1,
  output logic [PIX_W-1:0]         p_p0_p0,
  output logic [PIX_W-1:0]         p_p0_p1,
  output logic [PIX_W-1:0]         p_p0_p2,
  output logic [PIX_W-1:0]         p_p1_m2,
  output logic [PIX_W-1:0]         p_p1_m1,
  output logic [PIX_W-1:0]         p_p1_p0,
  output logic [PIX_W-1:0]         p_p1_p1,
  output logic [PIX_W-1:0]         p_p1_p2,
  output logic [PIX_W-1:0]         p_p2_m2,
  output logic [PIX_W-1:0]         p_p2_m1,
  output logic [PIX_W-1:0]         p_p2_p0,
  output logic [PIX_W-1:0]         p_p2_p1,
  output logic [PIX_W-1:0]         p_p2_p2,
  output logic                     start,
  output logic [$clog2(IMG_W)-1:0] cx,
  output logic [$clog2(IMG_H)-1:0] cy,
  output logic                     frame_done
);

  localparam int              c_CW       = $clog2(IMG_W);
  localparam int              c_RW       = $clog2(IMG_H);
  localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);

  logic [c_CW-1:0]  r_col;
  logic [c_RW-1:0]  r_row;
  logic [PIX_W-1:0] r_lb   [4][IMG_W];
  logic [PIX_W-1:0] r_win  [5][5];
  logic [PIX_W-1:0] r_tap  [5][5];
  logic             r_start;
  logic [c_CW-1:0]  r_cx;
  logic [c_RW-1:0]  r_cy;
  logic             r_frame_done;

  logic [c_CW-1:0]  w_col;
  logic [c_RW-1:0]  w_row;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_win_ok;
  logic [PIX_W-1:0] w_lb_rd  [4];
  logic [PIX_W-1:0] w_col_new[5];
  logic [PIX_W-1:0] w_win_nx [5][5];

  // sof re-bases the current pixel to (0,0) in the same cycle it is seen.
  assign w_col      = sof ? '0 : r_col;
  assign w_row      = sof ? '0 : r_row;
  assign w_col_last = (w_col == c_COL_LAST);
  assign w_row_last = (w_row == c_ROW_LAST);
  assign w_win_ok   = pix_valid && (w_row >= c_RW'(4)) && (w_col >= c_CW'(4));

  generate
    for (genvar k = 0; k < 4; k++) begin : g_lb_rd
      assign w_lb_rd[k] = r_lb[k][w_col];
    end
  endgenerate

  assign w_col_new[0] = w_lb_rd[3];
  assign w_col_new[1] = w_lb_rd[2];
  assign w_col_new[2] = w_lb_rd[1];
  assign w_col_new[3] = w_lb_rd[0];
  assign w_col_new[4] = pix_in;

  generate
    for (genvar r = 0; r < 5; r++) begin : g_win_r
      for (genvar c = 0; c < 5; c++) begin : g_win_c
        if (c < 4) begin : g_shift
          assign w_win_nx[r][c] = r_win[r][c+1];
        end else begin : g_load
          assign w_win_nx[r][c] = w_col_new[r];
        end
      end
    end
  endgenerate

  // Line buffer contents need no reset; they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_lb[0][w_col] <= pix_in;
      r_lb[1][w_col] <= w_lb_rd[0];
      r_lb[2][w_col] <= w_lb_rd[1];
      r_lb[3][w_col] <= w_lb_rd[2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_start      <= 1'b0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          r_win[i][j] <= '0;
          r_tap[i][j] <= '0;
        end
      end
    end else begin
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      if (pix_valid) begin
        r_col        <= w_col_last ? '0 : w_col + c_CW'(1);
        r_row        <= !w_col_last ? w_row : (w_row_last ? '0 : w_row + c_RW'(1));
        r_frame_done <= w_col_last && w_row_last;
        r_win        <= w_win_nx;
        // Taps are captured separately so they hold across border columns.
        if (w_win_ok) begin
          r_tap   <= w_win_nx;
          r_start <= 1'b1;
          r_cx    <= w_col - c_CW'(2);
          r_cy    <= w_row - c_RW'(2);
        end
      end else if (sof) begin
        r_col <= '0;
        r_row <= '0;
      end
    end
  end

  assign start      = r_start;
  assign cx         = r_cx;
  assign cy         = r_cy;
  assign frame_done = r_frame_done;

  assign p_m2_m2 = r_tap[0][0];
  assign p_m2_m1 = r_tap[0][1];
  assign p_m2_p0 = r_tap[0][2];
  assign p_m2_p1 = r_tap[0][3];
  assign p_m2_p2 = r_tap[0][4];
  assign p_m1_m2 = r_tap[1][0];
  assign p_m1_m1 = r_tap[1][1];
  assign p_m1_p0 = r_tap[1][2];
  assign p_m1_p1 = r_tap[1][3];
  assign p_m1_p2 = r_tap[1][4];
  assign p_p0_m2 = r_tap[2][0];
  assign p_p0_m1 = r_tap[2][1];
  assign p_p0_p0 = r_tap[2][2];
  assign p_p0_p1 = r_tap[2][3];
  assign p_p0_p2 = r_tap[2][4];
  assign p_p1_m2 = r_tap[3][0];
  assign p_p1_m1 = r_tap[3][1];
  assign p_p1_p0 = r_tap[3][2];
  assign p_p1_p1 = r_tap[3][3];
  assign p_p1_p2 = r_tap[3][4];
  assign p_p2_m2 = r_tap[4][0];
  assign p_p2_m1 = r_tap[4][1];
  assign p_p2_p0 = r_tap[4][2];
  assign p_p2_p1 = r_tap[4][3];
  assign p_p2_p2 = r_tap[4][4];

endmodule
`default_nettype wire

// File: tb/tb_cfa_window_5x5.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfa_window_5x5
// Brief    : Self-checking bench for cfa_window_5x5 on an 8x6 test image.
// Revision : 1.0
// ============================================================================
module tb_cfa_window_5x5;

  localparam int PW = 12;
  localparam int W  = 8;
  localparam int H  = 6;

  logic clk = 1'b0;
  logic rst, sof, pix_valid;
  logic [PW-1:0] pix_in;
  logic [PW-1:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2;
  logic [PW-1:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2;
  logic [PW-1:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2;
  logic [PW-1:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2;
  logic [PW-1:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2;
  logic start, frame_done;
  logic [2:0] cx, cy;
  logic [25*PW-1:0] w_taps;

  cfa_window_5x5 #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) u_dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
    .p_m2_m2(p_m2_m2), .p_m2_m1(p_m2_m1), .p_m2_p0(p_m2_p0), .p_m2_p1(p_m2_p1), .p_m2_p2(p_m2_p2),
    .p_m1_m2(p_m1_m2), .p_m1_m1(p_m1_m1), .p_m1_p0(p_m1_p0), .p_m1_p1(p_m1_p1), .p_m1_p2(p_m1_p2),
    .p_p0_m2(p_p0_m2), .p_p0_m1(p_p0_m1), .p_p0_p0(p_p0_p0), .p_p0_p1(p_p0_p1), .p_p0_p2(p_p0_p2),
    .p_p1_m2(p_p1_m2), .p_p1_m1(p_p1_m1), .p_p1_p0(p_p1_p0), .p_p1_p1(p_p1_p1), .p_p1_p2(p_p1_p2),
    .p_p2_m2(p_p2_m2), .p_p2_m1(p_p2_m1), .p_p2_p0(p_p2_p0), .p_p2_p1(p_p2_p1), .p_p2_p2(p_p2_p2),
    .start(start), .cx(cx), .cy(cy), .frame_done(frame_done)
  );

  assign w_taps = {p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2,
                   p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2,
                   p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2,
                   p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2,
                   p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2};

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       cx;
    logic [2:0]       cy;
    logic [25*PW-1:0] taps;
  } win_t;

  typedef struct {
    int          idx;
    logic [2:0]  cx;
    logic [2:0]  cy;
    logic [PW-1:0] m2m2, p0p0, p2p2, m2p2;
  } vec_t;

  win_t sb[$];
  win_t cap[$];
  vec_t tbl[4];
  win_t m_e;
  win_t m_c;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   n_dbl = 0;
  bit   prev_start = 1'b0;
  bit   cap_en = 1'b0;

  task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic win_t model(input int r, input int c);
    win_t e;
    e.cx   = 3'(c - 2);
    e.cy   = 3'(r - 2);
    e.taps = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        e.taps[(24 - (i*5 + j))*PW +: PW] = PW'((r - 4 + i)*16 + (c - 4 + j));
    return e;
  endfunction

  // Scoreboard consumer: every start pulse must match the oldest pending window.
  always @(negedge clk) begin
    if (!rst) begin
      if (start && prev_start) n_dbl++;
      prev_start = start;
      if (start) begin
        n_start++;
        m_c.cx = cx;
        m_c.cy = cy;
        m_c.taps = w_taps;
        if (cap_en) cap.push_back(m_c);
        chk("cx_range", 400'(cx >= 3'd2 && cx <= 3'd5), 400'(1));
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_start: got cx=%0d cy=%0d expected no window", cx, cy);
        end else begin
          m_e = sb.pop_front();
          chk("win_cx", 400'(cx), 400'(m_e.cx));
          chk("win_cy", 400'(cy), 400'(m_e.cy));
          chk("win_taps", 400'(w_taps), 400'(m_e.taps));
        end
      end
    end else begin
      prev_start = 1'b0;
    end
  end

  // One clock of stimulus, driven at negedge; checks start/frame_done after the edge.
  task automatic step(input bit v, input bit s, input int r, input int c,
                      input bit exp_win, input bit exp_fd);
    pix_valid = v;
    sof       = s;
    pix_in    = v ? PW'(r*16 + c) : PW'($urandom);
    if (exp_win) sb.push_back(model(r, c));
    @(posedge clk);
    @(negedge clk);
    chk("start_flag", 400'(start), 400'(exp_win));
    chk("frame_done", 400'(frame_done), 400'(exp_fd));
  endtask

  task automatic run_frame(input bit stall, input bit first_sof);
    int s0;
    s0 = n_start;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, first_sof && r == 0 && c == 0, r, c,
             r >= 4 && c >= 4, r == H-1 && c == W-1);
        if (stall) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      end
    end
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("frame_windows", 400'(n_start - s0), 400'((W-4)*(H-4)));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_taps"}, 400'(w_taps), 400'(0));
    chk({nm, "_start"}, 400'(start), 400'(0));
    chk({nm, "_cx"}, 400'(cx), 400'(0));
    chk({nm, "_cy"}, 400'(cy), 400'(0));
    chk({nm, "_fdone"}, 400'(frame_done), 400'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{idx: 0, cx: 3'd2, cy: 3'd2, m2m2: 12'd0,  p0p0: 12'd34, p2p2: 12'd68, m2p2: 12'd4};
    tbl[1] = '{idx: 3, cx: 3'd5, cy: 3'd2, m2m2: 12'd3,  p0p0: 12'd37, p2p2: 12'd71, m2p2: 12'd7};
    tbl[2] = '{idx: 4, cx: 3'd2, cy: 3'd3, m2m2: 12'd16, p0p0: 12'd50, p2p2: 12'd84, m2p2: 12'd20};
    tbl[3] = '{idx: 7, cx: 3'd5, cy: 3'd3, m2m2: 12'd19, p0p0: 12'd53, p2p2: 12'd87, m2p2: 12'd23};

    rst = 1'b1; sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // T1 nominal frame, captured for the table check
    cap_en = 1'b1;
    run_frame(1'b0, 1'b1);
    cap_en = 1'b0;
    chk("t1_count", 400'(cap.size()), 400'(8));
    for (int k = 0; k < 4; k++) begin
      if (tbl[k].idx >= cap.size()) begin
        n_cmp++;
        n_err++;
        $display("FAIL t1_table[%0d]: got %0d windows expected window %0d", k, cap.size(), tbl[k].idx);
      end else begin
        m_c = cap[tbl[k].idx];
        chk("t1_cx", 400'(m_c.cx), 400'(tbl[k].cx));
        chk("t1_cy", 400'(m_c.cy), 400'(tbl[k].cy));
        chk("t1_m2m2", 400'(m_c.taps[24*PW +: PW]), 400'(tbl[k].m2m2));
        chk("t1_p0p0", 400'(m_c.taps[12*PW +: PW]), 400'(tbl[k].p0p0));
        chk("t1_p2p2", 400'(m_c.taps[0 +: PW]), 400'(tbl[k].p2p2));
        chk("t1_m2p2", 400'(m_c.taps[20*PW +: PW]), 400'(tbl[k].m2p2));
      end
    end

    // T2 stall every other cycle
    n_dbl = 0;
    run_frame(1'b1, 1'b1);
    chk("t2_no_back_to_back", 400'(n_dbl), 400'(0));

    // T3 back-to-back frame relying on counter wrap (no sof)
    run_frame(1'b0, 1'b0);

    // T4 abandon a frame at (3,2) with sof, then a full frame
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c < 2) step(1'b1, 1'b0, r, c, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1);

    // T5 reset during row 4
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W; c++)
        if (r < 4 || c < 6) step(1'b1, 1'b0, r, c, r >= 4 && c >= 4, 1'b0);
    #2;
    pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("t5_rst_async");
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk_zero("t5_rst_held");
    rst = 1'b0;
    run_frame(1'b0, 1'b0);

    repeat (3) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("sb_drained", 400'(sb.size()), 400'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
